read_edges: RTL and testbench
=============================

READ_EDGES -- requirements
Module: read_edges

Interface
REQ-001 SHALL have port: clk  input  1  sole clock, all state on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-003 SHALL have port: i_data  input  pipeline_data_t  vertex record from read-source-property stage (src_id, src_prop, edge_base, edge_count valid).
REQ-004 SHALL have port: ready  input  1  i_data valid from previous stage.
REQ-005 SHALL have port: p_stall_can_accept  output  1  this stage can take a new vertex record.
REQ-006 SHALL have port: mem_req  output  1  one-cycle DRAM read request pulse.
REQ-007 SHALL have port: mem_addr  output  64  byte address of requested edge word.
REQ-008 SHALL have port: mem_data  input  64  edge word: [31:0] dst_id, [63:32] edge_weight.
REQ-009 SHALL have port: complete  input  1  DRAM read done, mem_data valid this cycle.
REQ-010 SHALL have port: n_stall_can_accept  input  1  next stage accepts o_data this cycle.
REQ-011 SHALL have port: o_valid  output  1  o_data holds a valid per-edge record.
REQ-012 SHALL have port: o_data  output  pipeline_data_t  input record plus dst_id, edge_weight, last_edge.

Function
REQ-013 SHALL implement states IDLE, REQ, WAIT_MEM, OUT.
REQ-014 SHALL drive p_stall_can_accept=1 only in IDLE; vertex accepted when ready=1 in IDLE.
REQ-015 On accept, SHALL latch i_data, clear 32-bit edge index to 0, go to REQ; if edge_count=0, SHALL drop the record and stay IDLE (no request, no output).
REQ-016 In REQ, SHALL assert mem_req=1 for exactly that cycle with mem_addr = edge_base + 8*index (64-bit, modulo 2^64), then go to WAIT_MEM.
REQ-017 mem_addr SHALL hold its value from REQ through WAIT_MEM; mem_req=0 in all other states.
REQ-018 In WAIT_MEM, SHALL wait any number of cycles for complete=1, then capture mem_data into o_data.dst_id/edge_weight and go to OUT.
REQ-019 complete SHALL be ignored in IDLE, REQ and OUT.
REQ-020 In OUT, SHALL hold o_valid=1 and o_data stable until n_stall_can_accept=1.
REQ-021 o_data.last_edge SHALL be 1 iff index = edge_count-1.
REQ-022 On OUT with n_stall_can_accept=1: if last_edge, go IDLE; else increment index and go REQ.
REQ-023 Per-edge latency: request issued 1 cycle after accept or after previous output transfer; o_valid rises 1 cycle after complete.
REQ-024 All non-edge fields of o_data SHALL equal the latched vertex record, unchanged across that vertex's edges.
REQ-025 ready while not in IDLE SHALL not alter latched record (upstream holds it).

Reset
REQ-026 reset=0 SHALL asynchronously force state IDLE, index 0, mem_req 0, mem_addr 0, o_valid 0, o_data all-zero.
REQ-027 p_stall_can_accept SHALL read 1 during and after reset (IDLE).
REQ-028 Reset mid-vertex SHALL abandon remaining edges; a complete arriving after reset release SHALL be ignored.

Structure
REQ-029 pipeline_data_t (with dst_id, edge_weight, last_edge fields) and edge word size constant (8 bytes) SHALL live in shared types package.
REQ-030 State enum SHALL be local to the module.
REQ-031 No sub-module is required; the edge index counter MAY be a separate edge_counter instance.

Verification
REQ-032 Reset with ready=1 held -> all outputs 0 except p_stall_can_accept=1; no mem_req.
REQ-033 Vertex edge_base=0x1000, edge_count=3, complete 2 cycles after each req, n_stall_can_accept=1 -> mem_addr 0x1000,0x1008,0x1010; three outputs, last_edge only on third; return to IDLE.
REQ-034 edge_count=0 -> no mem_req, no o_valid, p_stall_can_accept=1 next cycle.
REQ-035 n_stall_can_accept=0 for 5 cycles in OUT -> o_valid and o_data (dst_id=0x2A, edge_weight=0x7) stable; next req only after transfer.
REQ-036 reset=0 asserted in WAIT_MEM, complete pulsed after release -> state IDLE, o_valid stays 0.
REQ-037 edge_base=0xFFFF_FFFF_FFFF_FFF8, edge_count=2 -> second mem_addr wraps to 0x0.

Source files
------------

// File: rtl/read_edges_pkg.sv
// Shared types for the graph-processing pipeline: the per-vertex/per-edge record
// and the size of one edge word in DRAM.
package read_edges_pkg;

  // One edge word is {edge_weight, dst_id}, 8 bytes.
  localparam int unsigned EDGE_WORD_BYTES = 8;

  typedef struct packed {
    logic [31:0] src_id;
    logic [31:0] src_prop;
    logic [63:0] edge_base;
    logic [31:0] edge_count;
    logic [31:0] dst_id;
    logic [31:0] edge_weight;
    logic        last_edge;
  } pipeline_data_t;

  // Byte address of edge word idx; wraps modulo 2^64.
  function automatic logic [63:0] edge_addr(input logic [63:0] base, input logic [31:0] idx);
    return base + ({32'b0, idx} * 64'(EDGE_WORD_BYTES));
  endfunction

endpackage

// File: rtl/read_edges_edge_counter.sv
// Edge index counter for read_edges: cleared on vertex accept, bumped per edge.
module read_edges_edge_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_clear,
  input  logic        i_inc,
  output logic [31:0] o_count
);

  logic [31:0] r_count;

  // Clear takes priority so a new vertex always starts at edge 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + 32'd1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/read_edges.sv
// Read-edges stage: takes a vertex record, fetches each of its edge words from
// DRAM one at a time and emits one record per edge downstream.
module read_edges
  import read_edges_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  pipeline_data_t i_data,
  input  logic           ready,
  output logic           p_stall_can_accept,
  output logic           mem_req,
  output logic [63:0]    mem_addr,
  input  logic [63:0]    mem_data,
  input  logic           complete,
  input  logic           n_stall_can_accept,
  output logic           o_valid,
  output pipeline_data_t o_data
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_MEM, OUT} state_t;

  state_t         r_state;
  state_t         w_state_next;
  pipeline_data_t r_rec;
  pipeline_data_t r_o_data;
  pipeline_data_t w_out;
  logic [63:0]    r_mem_addr;
  logic [31:0]    w_index;
  logic           w_accept;
  logic           w_advance;
  logic           w_capture;

  read_edges_edge_counter u_edge_counter (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_accept),
    .i_inc   (w_advance),
    .o_count (w_index)
  );

  // Next-state and transfer strobes.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_advance    = 1'b0;
    w_capture    = 1'b0;
    unique case (r_state)
      IDLE: begin
        // Zero-edge vertices are consumed but produce nothing.
        if (ready && (i_data.edge_count != 32'd0)) begin
          w_accept     = 1'b1;
          w_state_next = REQ;
        end
      end
      REQ: begin
        w_state_next = WAIT_MEM;
      end
      WAIT_MEM: begin
        if (complete) begin
          w_capture    = 1'b1;
          w_state_next = OUT;
        end
      end
      OUT: begin
        if (n_stall_can_accept) begin
          if (r_o_data.last_edge) begin
            w_state_next = IDLE;
          end else begin
            w_advance    = 1'b1;
            w_state_next = REQ;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Per-edge output record: latched vertex fields plus the fetched edge word.
  always_comb begin
    w_out             = r_rec;
    w_out.dst_id      = mem_data[31:0];
    w_out.edge_weight = mem_data[63:32];
    w_out.last_edge   = (w_index == (r_rec.edge_count - 32'd1));
  end

  // State, latched vertex, request address and output record.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_rec      <= '0;
      r_o_data   <= '0;
      r_mem_addr <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_rec      <= i_data;
        r_mem_addr <= edge_addr(i_data.edge_base, 32'd0);
      end
      // Address is set up on entry to REQ so it is valid with the pulse and
      // holds through WAIT_MEM.
      if (w_advance) begin
        r_mem_addr <= edge_addr(r_rec.edge_base, w_index + 32'd1);
      end
      if (w_capture) begin
        r_o_data <= w_out;
      end
    end
  end

  assign p_stall_can_accept = (r_state == IDLE);
  assign mem_req            = (r_state == REQ);
  assign o_valid            = (r_state == OUT);
  assign mem_addr           = r_mem_addr;
  assign o_data             = r_o_data;

endmodule

// File: tb/tb_read_edges.sv
// Scoreboard bench for read_edges: a model expands each issued vertex into its
// expected requests and per-edge records; a DRAM responder and an output
// monitor pop and compare independently of the stimulus.
module tb_read_edges;
  import read_edges_pkg::*;

  logic           clk = 1'b0;
  logic           reset;
  pipeline_data_t i_data;
  logic           ready;
  logic           p_stall_can_accept;
  logic           mem_req;
  logic [63:0]    mem_addr;
  logic [63:0]    mem_data;
  logic           complete;
  logic           n_stall_can_accept;
  logic           o_valid;
  pipeline_data_t o_data;

  read_edges dut (
    .clk                (clk),
    .reset              (reset),
    .i_data             (i_data),
    .ready              (ready),
    .p_stall_can_accept (p_stall_can_accept),
    .mem_req            (mem_req),
    .mem_addr           (mem_addr),
    .mem_data           (mem_data),
    .complete           (complete),
    .n_stall_can_accept (n_stall_can_accept),
    .o_valid            (o_valid),
    .o_data             (o_data)
  );

  always #5 clk = ~clk;

  pipeline_data_t exp_q[$];
  logic [63:0]    addr_q[$];
  int             n_checks = 0;
  int             n_pass   = 0;
  int             req_cnt  = 0;
  int             out_cnt  = 0;
  int             mem_delay = 2;
  int             ns_mode  = 0;   // 0: always accept, 1: random, 2: stall
  logic           hold_mem = 1'b0;
  logic           ov_en    = 1'b0;
  logic [63:0]    ov_word  = '0;
  int             pulse_cnt = 0;
  logic [63:0]    last_req_addr = '0;

  function automatic void check(input string name, input logic [255:0] act,
                                input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  // Contents of DRAM at a given byte address.
  function automatic logic [63:0] mem_word(input logic [63:0] a);
    if (ov_en) return ov_word;
    return {a[63:32] + a[31:0] + 32'h0000_0101, a[34:3] ^ 32'h5A5A_0F0F};
  endfunction

  // Reference model: a vertex with N edges yields N reads at base+8k and N records.
  task automatic push_vertex(input pipeline_data_t v);
    pipeline_data_t e;
    logic [63:0]    a;
    logic [63:0]    w;
    for (int k = 0; k < int'(v.edge_count); k++) begin
      a = v.edge_base + 64'(k) * 64'd8;
      w = mem_word(a);
      e = v;
      e.dst_id      = w[31:0];
      e.edge_weight = w[63:32];
      e.last_edge   = (k == int'(v.edge_count) - 1);
      addr_q.push_back(a);
      exp_q.push_back(e);
    end
  endtask

  function automatic pipeline_data_t rand_vertex(input logic [63:0] base, input int cnt);
    pipeline_data_t v;
    v.src_id      = $urandom;
    v.src_prop    = $urandom;
    v.edge_base   = base;
    v.edge_count  = 32'(cnt);
    v.dst_id      = $urandom;
    v.edge_weight = $urandom;
    v.last_edge   = 1'($urandom_range(0, 1));
    return v;
  endfunction

  task automatic issue(input pipeline_data_t v);
    int t = 0;
    @(negedge clk);
    while (!p_stall_can_accept && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (!p_stall_can_accept) begin
      check("accept_timeout", 1'b0, 1'b1);
      return;
    end
    push_vertex(v);
    i_data = v;
    ready  = 1'b1;
    @(posedge clk);
    #1 ready = 1'b0;
    i_data = rand_vertex({$urandom, $urandom}, 5);
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    @(negedge clk);
    while (!(exp_q.size() == 0 && addr_q.size() == 0 && p_stall_can_accept) && t < 600) begin
      @(negedge clk);
      t++;
    end
    check(name, (exp_q.size() == 0 && addr_q.size() == 0 && p_stall_can_accept), 1'b1);
  endtask

  // Downstream handshake driver.
  initial begin
    n_stall_can_accept = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ns_mode == 0) n_stall_can_accept = 1'b1;
      else if (ns_mode == 2) n_stall_can_accept = 1'b0;
      else n_stall_can_accept = 1'($urandom_range(0, 1));
    end
  end

  // DRAM responder: checks each request address, answers after mem_delay cycles.
  initial begin
    int          pulse_done = 0;
    logic [63:0] a;
    complete = 1'b0;
    mem_data = '0;
    forever begin
      @(negedge clk);
      if (reset && mem_req) begin
        req_cnt++;
        a = mem_addr;
        last_req_addr = a;
        if (addr_q.size() == 0) check("unexpected_req", a, 64'hX);
        else check("mem_addr", a, addr_q.pop_front());
        if (!hold_mem) begin
          repeat (mem_delay) @(posedge clk);
          #1 complete = 1'b1;
          mem_data = mem_word(a);
          @(posedge clk);
          #1 complete = 1'b0;
          mem_data = {$urandom, $urandom};
        end
      end else if (pulse_done != pulse_cnt) begin
        pulse_done = pulse_cnt;
        @(posedge clk);
        #1 complete = 1'b1;
        mem_data = {$urandom, $urandom};
        @(posedge clk);
        #1 complete = 1'b0;
      end
    end
  end

  // Output monitor: every transfer must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset && o_valid && n_stall_can_accept) begin
      out_cnt++;
      if (exp_q.size() == 0) check("unexpected_output", o_data, 256'hX);
      else check("o_data", o_data, exp_q.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    pipeline_data_t v;
    int r0;
    int o0;
    int t;

    // Reset with ready held high.
    reset  = 1'b0;
    ready  = 1'b1;
    i_data = rand_vertex(64'h2000, 2);
    repeat (3) @(negedge clk);
    check("rst_can_accept", p_stall_can_accept, 1'b1);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_addr", mem_addr, 64'h0);
    check("rst_o_valid", o_valid, 1'b0);
    check("rst_o_data", o_data, 256'h0);
    check("rst_no_req", req_cnt, 0);
    ready = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;

    // Three edges from 0x1000, responses two cycles after each request.
    mem_delay = 2;
    ns_mode   = 0;
    r0 = req_cnt;
    o0 = out_cnt;
    issue(rand_vertex(64'h1000, 3));
    @(negedge clk);
    check("req_latency", mem_req, 1'b1);
    wait_drain("three_edge_drain");
    check("three_edge_reqs", req_cnt - r0, 3);
    check("three_edge_outs", out_cnt - o0, 3);

    // Zero-edge vertex is dropped.
    r0 = req_cnt;
    o0 = out_cnt;
    issue(rand_vertex(64'h3000, 0));
    @(negedge clk);
    check("zero_edge_can_accept", p_stall_can_accept, 1'b1);
    repeat (4) @(negedge clk);
    check("zero_edge_reqs", req_cnt - r0, 0);
    check("zero_edge_outs", out_cnt - o0, 0);

    // Downstream stall holds the record and blocks the next request.
    ov_en   = 1'b1;
    ov_word = {32'h0000_0007, 32'h0000_002A};
    ns_mode = 2;
    mem_delay = 1;
    issue(rand_vertex(64'h4000, 2));
    t = 0;
    @(negedge clk);
    while (!o_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("stall_dst_id", o_data.dst_id, 32'h2A);
    check("stall_weight", o_data.edge_weight, 32'h7);
    r0 = req_cnt;
    for (int i = 0; i < 5; i++) begin
      check("stall_o_valid", o_valid, 1'b1);
      if (exp_q.size() != 0) check("stall_o_data", o_data, exp_q[0]);
      @(negedge clk);
    end
    check("stall_no_req", req_cnt - r0, 0);
    ns_mode = 0;
    wait_drain("stall_drain");
    ov_en = 1'b0;

    // Reset while waiting on memory; a late complete must be ignored.
    hold_mem = 1'b1;
    issue(rand_vertex(64'h5000, 3));
    @(negedge clk);
    check("midrst_req", mem_req, 1'b1);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check("midrst_can_accept", p_stall_can_accept, 1'b1);
    check("midrst_o_valid", o_valid, 1'b0);
    check("midrst_mem_addr", mem_addr, 64'h0);
    exp_q.delete();
    addr_q.delete();
    @(posedge clk);
    #2 reset = 1'b1;
    hold_mem = 1'b0;
    r0 = req_cnt;
    o0 = out_cnt;
    pulse_cnt++;
    repeat (6) @(negedge clk);
    check("midrst_no_req", req_cnt - r0, 0);
    check("midrst_no_out", out_cnt - o0, 0);
    check("midrst_idle", p_stall_can_accept, 1'b1);

    // Address wraps past 2^64.
    mem_delay = 1;
    issue(rand_vertex(64'hFFFF_FFFF_FFFF_FFF8, 2));
    wait_drain("wrap_drain");
    check("wrap_addr", last_req_addr, 64'h0);

    // Randomized traffic.
    ns_mode = 1;
    for (int n = 0; n < 30; n++) begin
      mem_delay = $urandom_range(1, 4);
      v = rand_vertex({$urandom, $urandom}, $urandom_range(0, 4));
      issue(v);
    end
    wait_drain("random_drain");
    check("random_scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
